// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel-rate enable, h/v counters, active-low syncs and blank.
// Flags are registered from the next counter values so they line up with hcount/vcount.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk_in,
    input  logic        reset,
    output logic        pix_en,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        blank,
    output logic        hSync,
    output logic        vSync,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS_END  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_FIRST   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);

    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS_END  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_pix_en;
    logic [10:0]      r_hcount;
    logic [9:0]       r_vcount;
    logic             r_blank;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_frame_start;

    logic [DIV_W-1:0] w_div_next;
    logic             w_pix_next;
    logic             w_line_end;
    logic [10:0]      w_h_next;
    logic [9:0]       w_v_next;
    logic             w_blank_next;
    logic             w_hsync_next;
    logic             w_vsync_next;
    logic             w_fs_next;

    // pix_en is registered (not decoded) so it stays low in reset even when CLK_DIV is 1
    always_comb begin
        w_div_next = (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DIV_W'(1);
        w_pix_next = (w_div_next == DIV_LAST);
    end

    always_comb begin
        w_line_end = (r_hcount == H_LAST);
        w_h_next   = r_hcount;
        w_v_next   = r_vcount;
        if (r_pix_en) begin
            if (w_line_end) begin
                w_h_next = '0;
                w_v_next = (r_vcount == V_LAST) ? '0 : r_vcount + 10'd1;
            end else begin
                w_h_next = r_hcount + 11'd1;
            end
        end
    end

    // Flags look at the next counts so that, once registered, they match the presented counts
    always_comb begin
        w_blank_next = (w_h_next >= H_VIS_END) || (w_v_next >= V_VIS_END);
        w_hsync_next = !((w_h_next >= HS_FIRST) && (w_h_next <= HS_LAST));
        w_vsync_next = !((w_v_next >= VS_FIRST) && (w_v_next <= VS_LAST));
        w_fs_next    = w_pix_next && (w_h_next == '0) && (w_v_next == '0);
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_div_cnt     <= '0;
            r_pix_en      <= 1'b0;
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_blank       <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_div_cnt     <= w_div_next;
            r_pix_en      <= w_pix_next;
            r_hcount      <= w_h_next;
            r_vcount      <= w_v_next;
            r_blank       <= w_blank_next;
            r_hsync       <= w_hsync_next;
            r_vsync       <= w_vsync_next;
            r_frame_start <= w_fs_next;
        end
    end

    assign pix_en      = r_pix_en;
    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign blank       = r_blank;
    assign hSync       = r_hsync;
    assign vSync       = r_vsync;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480/4, CLK_DIV=1, and a shrunk 14x7/2 raster.
// After reset release, edge c puts the raster at pixel floor(c/CLK_DIV) (c-1 when CLK_DIV=1).
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, rst_c;
    logic        pe_a, bl_a, hs_a, vs_a, fs_a;
    logic [10:0] hc_a;
    logic [9:0]  vc_a;
    logic        pe_b, bl_b, hs_b, vs_b, fs_b;
    logic [10:0] hc_b;
    logic [9:0]  vc_b;
    logic        pe_c, bl_c, hs_c, vs_c, fs_c;
    logic [10:0] hc_c;
    logic [9:0]  vc_c;

    int tests = 0;
    int fails = 0;

    vga_timing_gen u_a (
        .clk_in(clk), .reset(rst_a), .pix_en(pe_a), .hcount(hc_a), .vcount(vc_a),
        .blank(bl_a), .hSync(hs_a), .vSync(vs_a), .frame_start(fs_a)
    );

    vga_timing_gen #(.CLK_DIV(1)) u_b (
        .clk_in(clk), .reset(rst_b), .pix_en(pe_b), .hcount(hc_b), .vcount(vc_b),
        .blank(bl_b), .hSync(hs_b), .vSync(vs_b), .frame_start(fs_b)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_c (
        .clk_in(clk), .reset(rst_c), .pix_en(pe_c), .hcount(hc_c), .vcount(vc_c),
        .blank(bl_c), .hSync(hs_c), .vSync(vs_c), .frame_start(fs_c)
    );

    task automatic test_reset();
        int errs, e_pe, e_fs;
        errs = 0; e_pe = 0; e_fs = 0;
        rst_a = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if ({pe_a, hc_a, vc_a, bl_a, hs_a, vs_a, fs_a} !==
                {1'b0, 11'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0}) errs++;
        end
        tests++;
        if (errs !== 0) begin
            fails++;
            $display("FAIL reset_values: %0d bad cycles, expected 0", errs);
        end
        rst_a = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (pe_a !== ((c % 4) == 3)) e_pe++;
            if (fs_a !== (c == 3)) e_fs++;
        end
        tests++;
        if (e_pe !== 0) begin
            fails++;
            $display("FAIL reset_pix_en_pattern: %0d bad cycles, expected 0", e_pe);
        end
        tests++;
        if (e_fs !== 0) begin
            fails++;
            $display("FAIL reset_frame_start_cycle4: %0d bad cycles, expected 0", e_fs);
        end
    endtask

    task automatic test_line();
        int h, v, e_h, e_v, e_pe, e_bl, e_hs, e_vs, e_fs, hs_low, first_low;
        logic [9:0] v_before, v_after;
        e_h = 0; e_v = 0; e_pe = 0; e_bl = 0; e_hs = 0; e_vs = 0; e_fs = 0;
        hs_low = 0; first_low = -1; v_before = '1; v_after = '0;
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        for (int c = 1; c <= 3204; c++) begin
            @(negedge clk);
            h = (c / 4) % 800;
            v = (c / 3200) % 525;
            if (hc_a !== 11'(h)) e_h++;
            if (vc_a !== 10'(v)) e_v++;
            if (pe_a !== ((c % 4) == 3)) e_pe++;
            if (bl_a !== ((h >= 640) || (v >= 480))) e_bl++;
            if (hs_a !== !((h >= 656) && (h <= 751))) e_hs++;
            if (vs_a !== 1'b1) e_vs++;
            if (fs_a !== (c == 3)) e_fs++;
            if (c <= 3200 && hs_a == 1'b0) begin
                hs_low++;
                if (first_low < 0) first_low = c;
            end
            if (c == 3199) v_before = vc_a;
            if (c == 3200) v_after = vc_a;
        end
        tests++;
        if (e_h !== 0) begin fails++; $display("FAIL line_hcount: %0d bad cycles, expected 0", e_h); end
        tests++;
        if (e_v !== 0) begin fails++; $display("FAIL line_vcount: %0d bad cycles, expected 0", e_v); end
        tests++;
        if (e_pe !== 0) begin fails++; $display("FAIL line_pix_en: %0d bad cycles, expected 0", e_pe); end
        tests++;
        if (e_bl !== 0) begin fails++; $display("FAIL line_blank: %0d bad cycles, expected 0", e_bl); end
        tests++;
        if (e_hs !== 0) begin fails++; $display("FAIL line_hsync: %0d bad cycles, expected 0", e_hs); end
        tests++;
        if (e_vs !== 0) begin fails++; $display("FAIL line_vsync: %0d bad cycles, expected 0", e_vs); end
        tests++;
        if (e_fs !== 0) begin fails++; $display("FAIL line_frame_start: %0d bad cycles, expected 0", e_fs); end
        tests++;
        if (hs_low !== 384) begin fails++; $display("FAIL line_hsync_width: got %0d, expected 384", hs_low); end
        tests++;
        if (first_low !== 2624) begin fails++; $display("FAIL line_hsync_fall: got %0d, expected 2624", first_low); end
        tests++;
        if ({v_before, v_after} !== {10'd0, 10'd1}) begin
            fails++;
            $display("FAIL line_vcount_wrap: got %0d->%0d, expected 0->1", v_before, v_after);
        end
    endtask

    task automatic test_async_reset();
        int e_fs, e_pos;
        e_fs = 0; e_pos = 0;
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        repeat (4400) @(negedge clk);
        tests++;
        if ({hc_a, vc_a} !== {11'd300, 10'd1}) begin
            fails++;
            $display("FAIL async_pos: got h=%0d v=%0d, expected h=300 v=1", hc_a, vc_a);
        end
        #2;
        rst_a = 1'b0;
        #1;
        tests++;
        if ({pe_a, hc_a, vc_a, bl_a, hs_a, vs_a, fs_a} !==
            {1'b0, 11'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL async_reset_values: got pe=%b h=%0d v=%0d bl=%b hs=%b vs=%b fs=%b, expected 0 0 0 0 1 1 0",
                     pe_a, hc_a, vc_a, bl_a, hs_a, vs_a, fs_a);
        end
        @(negedge clk);
        rst_a = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (fs_a !== (c == 3)) e_fs++;
            if ({hc_a, vc_a} !== {11'(c / 4), 10'd0}) e_pos++;
        end
        tests++;
        if (e_fs !== 0) begin fails++; $display("FAIL async_restart_fs: %0d bad cycles, expected 0", e_fs); end
        tests++;
        if (e_pos !== 0) begin fails++; $display("FAIL async_restart_pos: %0d bad cycles, expected 0", e_pos); end
    endtask

    task automatic test_clkdiv1();
        int h, v, e_all, e_pe, hs_low, first_h, fs_cnt;
        logic [20:0] end_pos, wrap_pos;
        e_all = 0; e_pe = 0; hs_low = 0; first_h = -1; fs_cnt = 0;
        end_pos = '0; wrap_pos = '0;
        rst_b = 1'b0;
        @(negedge clk);
        tests++;
        if (pe_b !== 1'b0) begin fails++; $display("FAIL div1_pix_en_reset: got %b, expected 0", pe_b); end
        rst_b = 1'b1;
        for (int c = 1; c <= 900; c++) begin
            @(negedge clk);
            h = (c - 1) % 800;
            v = (c - 1) / 800;
            if (pe_b !== 1'b1) e_pe++;
            if ({hc_b, vc_b} !== {11'(h), 10'(v)}) e_all++;
            if (hs_b !== !((h >= 656) && (h <= 751))) e_all++;
            if (bl_b !== (h >= 640)) e_all++;
            if (c <= 800 && hs_b == 1'b0) begin
                hs_low++;
                if (first_h < 0) first_h = int'(hc_b);
            end
            if (fs_b == 1'b1) fs_cnt++;
            if (c == 800) end_pos = {hc_b, vc_b};
            if (c == 801) wrap_pos = {hc_b, vc_b};
        end
        tests++;
        if (e_pe !== 0) begin fails++; $display("FAIL div1_pix_en_high: %0d bad cycles, expected 0", e_pe); end
        tests++;
        if (e_all !== 0) begin fails++; $display("FAIL div1_raster: %0d bad checks, expected 0", e_all); end
        tests++;
        if (hs_low !== 96) begin fails++; $display("FAIL div1_hsync_width: got %0d, expected 96", hs_low); end
        tests++;
        if (first_h !== 656) begin fails++; $display("FAIL div1_hsync_start: got %0d, expected 656", first_h); end
        tests++;
        if ({end_pos, wrap_pos} !== {11'd799, 10'd0, 11'd0, 10'd1}) begin
            fails++;
            $display("FAIL div1_line_len: got %h/%h, expected h799v0 then h0v1", end_pos, wrap_pos);
        end
        tests++;
        if (fs_cnt !== 1) begin fails++; $display("FAIL div1_frame_start: got %0d pulses, expected 1", fs_cnt); end
    endtask

    task automatic test_small_frame();
        int h, v, e_all, fs_cnt, vs_low;
        logic [20:0] p27, p28, p195, p196;
        logic [2:0]  f195, f196;
        e_all = 0; fs_cnt = 0; vs_low = 0;
        p27 = '0; p28 = '0; p195 = '0; p196 = '0; f195 = '0; f196 = '0;
        rst_c = 1'b0;
        @(negedge clk);
        rst_c = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            h = (c / 2) % 14;
            v = (c / 28) % 7;
            if ({hc_c, vc_c} !== {11'(h), 10'(v)}) e_all++;
            if (pe_c !== ((c % 2) == 1)) e_all++;
            if (bl_c !== ((h >= 8) || (v >= 4))) e_all++;
            if (hs_c !== !((h >= 10) && (h <= 11))) e_all++;
            if (vs_c !== (v != 5)) e_all++;
            if (fs_c !== ((c % 196) == 1)) e_all++;
            if (c <= 392 && fs_c == 1'b1) fs_cnt++;
            if (c <= 196 && vs_c == 1'b0) vs_low++;
            if (c == 27) p27 = {hc_c, vc_c};
            if (c == 28) p28 = {hc_c, vc_c};
            if (c == 195) begin p195 = {hc_c, vc_c}; f195 = {bl_c, hs_c, vs_c}; end
            if (c == 196) begin p196 = {hc_c, vc_c}; f196 = {bl_c, hs_c, vs_c}; end
        end
        tests++;
        if (e_all !== 0) begin fails++; $display("FAIL small_raster: %0d bad checks, expected 0", e_all); end
        tests++;
        if ({p27, p28} !== {11'd13, 10'd0, 11'd0, 10'd1}) begin
            fails++;
            $display("FAIL small_h_wrap: got %h/%h, expected h13v0 then h0v1", p27, p28);
        end
        tests++;
        if ({p195, f195, p196, f196} !== {11'd13, 10'd6, 3'b111, 11'd0, 10'd0, 3'b011}) begin
            fails++;
            $display("FAIL small_v_wrap: got %h %b / %h %b, expected h13v6 111 then h0v0 011",
                     p195, f195, p196, f196);
        end
        tests++;
        if (fs_cnt !== 2) begin fails++; $display("FAIL small_frame_start: got %0d pulses, expected 2", fs_cnt); end
        tests++;
        if (vs_low !== 28) begin fails++; $display("FAIL small_vsync_width: got %0d, expected 28", vs_low); end
    endtask

    task automatic test_small_reset();
        int e_fs;
        e_fs = 0;
        rst_c = 1'b0;
        @(negedge clk);
        rst_c = 1'b1;
        repeat (94) @(negedge clk);
        tests++;
        if ({hc_c, vc_c} !== {11'd5, 10'd3}) begin
            fails++;
            $display("FAIL small_mid_pos: got h=%0d v=%0d, expected h=5 v=3", hc_c, vc_c);
        end
        #2;
        rst_c = 1'b0;
        #1;
        tests++;
        if ({pe_c, hc_c, vc_c, bl_c, hs_c, vs_c, fs_c} !==
            {1'b0, 11'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL small_async_values: got pe=%b h=%0d v=%0d bl=%b hs=%b vs=%b fs=%b, expected 0 0 0 0 1 1 0",
                     pe_c, hc_c, vc_c, bl_c, hs_c, vs_c, fs_c);
        end
        @(negedge clk);
        rst_c = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (fs_c !== (c == 1)) e_fs++;
        end
        tests++;
        if (e_fs !== 0) begin fails++; $display("FAIL small_restart_fs: %0d bad cycles, expected 0", e_fs); end
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        test_reset();
        test_line();
        test_async_reset();
        test_clkdiv1();
        test_small_frame();
        test_small_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480 @ 60 Hz VGA output path. It divides the board clock down to a pixel-rate enable and runs the horizontal and vertical pixel counters. It drives the active-low sync pulses and the blanking flag. It sits directly upstream of the VGA output/pixel-colour stage, which consumes `hcount`, `vcount` and `blank` to choose `redOut`/`greenOut`/`blueOut`, and forwards `hSync`/`vSync` to the connector.

## Interface
Parameters:
- `CLK_DIV`, 4: `clk_in` cycles per pixel (100 MHz -> 25 MHz). Legal values are 1 or more.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels. H_TOTAL = 800.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines. V_TOTAL = 525.

Ports:
- `clk_in`  in  1  board clock; the only clock in the block.
- `reset`  in  1  asynchronous, active-low reset.
- `pix_en`  out  1  one-`clk_in`-cycle pulse marking the last cycle of the current pixel.
- `hcount`  out  11  current pixel column, 0..H_TOTAL-1.
- `vcount`  out  10  current line, 0..V_TOTAL-1.
- `blank`  out  1  high outside the visible area.
- `hSync`  out  1  horizontal sync, active low.
- `vSync`  out  1  vertical sync, active low.
- `frame_start`  out  1  high only in the `pix_en` cycle of pixel (0,0).

## Operation
- The divider counter `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - `pix_en` = (`div_cnt` == CLK_DIV-1).
  - With CLK_DIV = 1, `pix_en` is constantly high once out of reset.
- Each (`hcount`,`vcount`) pair is held for CLK_DIV cycles. The counters advance only on the edge that ends a `pix_en` cycle.
  - `hcount` == H_TOTAL-1: `hcount` goes to 0 and `vcount` advances.
  - Otherwise: `hcount` increments and `vcount` holds.
  - `vcount` wraps from V_TOTAL-1 to 0, and only when `hcount` also wraps.
- `hSync` is low exactly while `hcount` is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = 656..751.
- `vSync` is low exactly while `vcount` is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = 490..491. This applies over the full line, independent of `hcount`.
- `blank` = (`hcount` >= H_ACTIVE) OR (`vcount` >= V_ACTIVE).
- `hSync`, `vSync` and `blank` are registered. They are computed from the next counter values, so they always describe the `hcount`/`vcount` presented in the same cycle. There is no skew between counts and flags.
- `frame_start` = `pix_en` AND `hcount`==0 AND `vcount`==0. It is decoded from registered state only and is glitch-free.
- Comparisons use unsigned arithmetic at counter width. No counter ever exceeds its TOTAL-1.

## Timing
- While `reset` is low, asynchronously: `div_cnt`=0, `hcount`=0, `vcount`=0, `hSync`=1, `vSync`=1, `blank`=0, `pix_en`=0, `frame_start`=0.
- After release, with CLK_DIV=4:
  - `pix_en` is first high in the 4th `clk_in` cycle, then every 4th cycle.
  - `frame_start` pulses coincident with that first `pix_en`.
- Line period: H_TOTAL×CLK_DIV = 3200 `clk_in` cycles.
- Frame period: 525×3200 = 1,680,000 `clk_in` cycles.
- `hSync` low pulse: 96 pixels = 384 `clk_in` cycles. It falls 656×4 = 2624 cycles after the start of each line.
- `vSync` low pulse: 2 lines = 6400 `clk_in` cycles.
- Reset asserted mid-frame: all outputs take their reset values immediately, with no clock needed. After release the raster restarts at pixel (0,0). No partial state is kept.
- Latency from counters to flags: 0 cycles (flags are aligned with counts).

## Test plan
1. Hold `reset` low for 10 cycles, then release.
   - All outputs at reset values while reset is low.
   - `pix_en` pattern 0,0,0,1 repeating.
   - `frame_start`=1 only in cycle 4.
2. Run one full line.
   - `hcount` steps 0..799 and then returns to 0.
   - `blank`=1 for `hcount` 640..799.
   - `hSync`=0 only for `hcount` 656..751, which is 384 cycles.
   - `vcount` goes 0 -> 1 exactly at the wrap.
3. Run one full frame.
   - `vSync`=0 only for `vcount` 490..491, which is 6400 cycles.
   - `blank`=1 for all of `vcount` 480..524.
   - `vcount` wraps from 524 to 0.
   - Exactly one `frame_start` pulse per 1,680,000 cycles.
4. Assert `reset` asynchronously, between clock edges, at (`hcount`=300, `vcount`=200).
   - Outputs go to reset values before the next edge.
   - After release, the next `frame_start` occurs 4 cycles later.
5. Rebuild with CLK_DIV=1.
   - `pix_en` stays at 1.
   - Line is 800 cycles.
   - `hSync` low for 96 cycles starting at cycle 656.
6. Shrink the parameters (H: 8/2/2/2, V: 4/1/1/1, CLK_DIV=2).
   - H_TOTAL=14 and V_TOTAL=7.
   - Sync and blank windows fall exactly at the boundaries computed from the formulas, including both wrap points.
